// File: rtl/param_fir_filter.sv
// rtl/param_fir_filter.sv - parametrised pipelined FIR filter with double-buffered coefficients
//
// Direct-form FIR filter with TAPS taps and signed fixed-point data. Coefficients
// are written into a shadow bank and copied into the active bank on commit.
// The pipeline is accept -> products -> rounded/saturated sum, so a result
// appears exactly two edges after its sample is accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous clear of delay line and pipeline (beats in_valid)
//   in_valid     in_data carries a sample this cycle
//   in_data      input sample, INP_FRAC fractional bits
//   coef_we      write coef_data into shadow[coef_addr]
//   coef_addr    shadow tap index, 0 = newest sample; indices >= TAPS ignored
//   coef_data    coefficient, COEF_FRAC fractional bits
//   coef_commit  copy shadow bank (including a same-cycle write) to active bank
//   out_valid    one-cycle pulse per result
//   out_data     filtered sample, OUT_FRAC fractional bits; holds between pulses
module param_fir_filter #(
    parameter int TAPS      = 6,
    parameter int INP_W     = 16,
    parameter int INP_FRAC  = 14,
    parameter int COEF_W    = 14,
    parameter int COEF_FRAC = 13,
    parameter int OUT_W     = 26,
    parameter int OUT_FRAC  = 22,
    parameter int SAT       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic signed [INP_W-1:0]     in_data,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    input  logic                        coef_commit,
    output logic                        out_valid,
    output logic signed [OUT_W-1:0]     out_data
);

    localparam int AW      = $clog2(TAPS);
    localparam int PW      = INP_W + COEF_W;
    localparam int D       = INP_FRAC + COEF_FRAC - OUT_FRAC;
    // Significant bits of a rounded term; the accumulator is sized so that
    // TAPS such terms never overflow before saturation is decided.
    localparam int TERM_W  = PW + 1 - D;
    localparam int RW      = (TERM_W > OUT_W) ? TERM_W : OUT_W;
    localparam int SUM_W   = RW + AW;
    localparam logic signed [PW:0] RND = (PW+1)'(1) << (D - 1);

    logic signed [INP_W-1:0]  taps        [TAPS];
    logic signed [COEF_W-1:0] shadow      [TAPS];
    logic signed [COEF_W-1:0] shadow_next [TAPS];
    logic signed [COEF_W-1:0] active      [TAPS];
    logic signed [PW-1:0]     prod        [TAPS];
    logic signed [SUM_W-1:0]  term        [TAPS];
    logic signed [SUM_W-1:0]  sum;
    logic signed [OUT_W-1:0]  result;
    logic                     ovf;
    logic                     s0;
    logic                     v1;

    // Shadow bank with this cycle's write applied, so a commit in the same
    // cycle as a write picks the new value up.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            shadow_next[k] = shadow[k];
            if (coef_we && coef_addr == AW'(k))
                shadow_next[k] = coef_data;
        end
    end

    // Round half-up (ties toward +inf) by adding half an output LSB before the
    // arithmetic shift; the extra top bit keeps that addition from overflowing.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            term[k] = SUM_W'(($signed({prod[k][PW-1], prod[k]}) + RND) >>> D);
            sum     = sum + term[k];
        end
    end

    // Overflow when the bits above the output sign bit are not all copies of it.
    always_comb begin
        ovf = !((&sum[SUM_W-1:OUT_W-1]) || !(|sum[SUM_W-1:OUT_W-1]));
        if (SAT != 0 && ovf)
            result = sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
            result = sum[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                taps[k]   <= '0;
                shadow[k] <= '0;
                active[k] <= '0;
                prod[k]   <= '0;
            end
            s0        <= 1'b0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= shadow_next[k];
                if (coef_commit)
                    active[k] <= shadow_next[k];
            end
            if (flush) begin
                for (int k = 0; k < TAPS; k++) begin
                    taps[k] <= '0;
                    prod[k] <= '0;
                end
                s0        <= 1'b0;
                v1        <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (in_valid) begin
                    taps[0] <= in_data;
                    for (int k = 1; k < TAPS; k++)
                        taps[k] <= taps[k-1];
                end
                // Products use the pre-edge active bank, so a commit at this
                // edge only affects samples accepted at or after it.
                for (int k = 0; k < TAPS; k++)
                    prod[k] <= PW'(taps[k]) * PW'(active[k]);
                s0        <= in_valid;
                v1        <= s0;
                out_valid <= v1;
                if (v1)
                    out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_param_fir_filter.sv
// tb/tb_param_fir_filter.sv - directed self-checking bench for param_fir_filter
module tb_param_fir_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [13:0] coef_data;
    logic        coef_commit;
    logic        out_valid;
    logic [25:0] out_data;
    logic        out_valid_ns;
    logic [25:0] out_data_ns;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected-result pipeline: stage 2 is what should be on the outputs now.
    logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic [25:0] e0 = '0, e1 = '0, e2 = '0;
    logic [25:0] n0 = '0, n1 = '0, n2 = '0;
    logic [25:0] last_e = '0, last_n = '0;

    logic [25:0] sat_pos_s [6] = '{26'h07FFB00, 26'h0FFF600, 26'h17FF100, 26'h1FFEC00, 26'h1FFFFFF, 26'h1FFFFFF};
    logic [25:0] sat_pos_n [6] = '{26'h07FFB00, 26'h0FFF600, 26'h17FF100, 26'h1FFEC00, 26'h27FE700, 26'h2FFE200};
    logic [25:0] sat_neg_s [6] = '{26'h3800400, 26'h3000800, 26'h2800C00, 26'h2001000, 26'h2000000, 26'h2000000};
    logic [25:0] sat_neg_n [6] = '{26'h3800400, 26'h3000800, 26'h2800C00, 26'h2001000, 26'h1801400, 26'h1001800};

    always #5 clk = ~clk;

    param_fir_filter dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .out_valid(out_valid), .out_data(out_data)
    );

    param_fir_filter #(.SAT(0)) dut_ns (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .out_valid(out_valid_ns), .out_data(out_data_ns)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive sample, take the edge, then check both DUTs.
    task automatic tick(input logic v, input logic [15:0] d, input logic [25:0] es, input logic [25:0] en);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (flush) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        end else begin
            h2 = h1; e2 = e1; n2 = n1;
            h1 = h0; e1 = e0; n1 = n0;
            h0 = v;  e0 = es; n0 = en;
        end
        #1;
        coef_we = 1'b0; coef_commit = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("out_valid", {31'd0, out_valid}, {31'd0, h2});
        check("out_valid_nosat", {31'd0, out_valid_ns}, {31'd0, h2});
        if (h2) begin
            check("out_data", {6'd0, out_data}, {6'd0, e2});
            check("out_data_nosat", {6'd0, out_data_ns}, {6'd0, n2});
            last_e = e2;
            last_n = n2;
        end else begin
            check("hold_data", {6'd0, out_data}, {6'd0, last_e});
            check("hold_data_nosat", {6'd0, out_data_ns}, {6'd0, last_n});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, '0, '0);
    endtask

    task automatic wr(input int a, input logic [13:0] c, input logic com);
        coef_we     = 1'b1;
        coef_addr   = a[2:0];
        coef_data   = c;
        coef_commit = com;
        tick(1'b0, 16'h0000, '0, '0);
    endtask

    task automatic load_all(input logic [13:0] c);
        for (int i = 0; i < 6; i++) wr(i, c, 1'b0);
        coef_commit = 1'b1;
        tick(1'b0, 16'h0000, '0, '0);
    endtask

    task automatic do_flush(input logic v);
        flush = 1'b1;
        tick(v, 16'h4000, '0, '0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", {6'd0, out_data}, 32'd0);
        rst = 1'b0;

        // Impulse, contiguous
        load_all(14'h1000);
        tick(1'b1, 16'h4000, 26'h0200000, 26'h0200000);
        for (int i = 0; i < 5; i++) tick(1'b1, 16'h0000, 26'h0200000, 26'h0200000);
        tick(1'b1, 16'h0000, 26'h0, 26'h0);
        idle(2);

        // Impulse with bubbles; garbage on in_data while in_valid=0
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, (i == 0) ? 16'h4000 : 16'h0000, (i < 6) ? 26'h0200000 : 26'h0, (i < 6) ? 26'h0200000 : 26'h0);
            if (i < 6) begin
                tick(1'b0, 16'h7FFF, '0, '0);
                tick(1'b0, 16'h7FFF, '0, '0);
            end
        end
        idle(2);

        // Rounding
        wr(0, 14'h0010, 1'b0);
        for (int i = 1; i < 6; i++) wr(i, 14'h0000, 1'b0);
        coef_commit = 1'b1;
        tick(1'b0, 16'h0000, '0, '0);
        tick(1'b1, 16'h0001, 26'h0000001, 26'h0000001);
        tick(1'b1, 16'hFFFF, 26'h0000000, 26'h0000000);
        tick(1'b1, 16'h0002, 26'h0000001, 26'h0000001);
        tick(1'b1, 16'hFFFE, 26'h3FFFFFF, 26'h3FFFFFF);
        idle(2);

        // Saturation vs wrap
        load_all(14'h1FFF);
        do_flush(1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 16'h7FFF, sat_pos_s[i], sat_pos_n[i]);
        idle(2);
        do_flush(1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 16'h8000, sat_neg_s[i], sat_neg_n[i]);
        idle(2);

        // Coefficient swap mid-stream
        load_all(14'h1000);
        do_flush(1'b0);
        for (int i = 1; i <= 6; i++) tick(1'b1, 16'h4000, 26'h0200000 * 26'(i), 26'h0200000 * 26'(i));
        for (int i = 0; i < 5; i++) begin
            coef_we = 1'b1; coef_addr = i[2:0]; coef_data = 14'h0800;
            tick(1'b1, 16'h4000, 26'h0C00000, 26'h0C00000);
        end
        coef_we = 1'b1; coef_addr = 3'd7; coef_data = 14'h1FFF;
        tick(1'b1, 16'h4000, 26'h0C00000, 26'h0C00000);
        coef_we = 1'b1; coef_addr = 3'd5; coef_data = 14'h1800; coef_commit = 1'b1;
        tick(1'b1, 16'h4000, 26'h0800000, 26'h0800000);
        for (int i = 0; i < 3; i++) tick(1'b1, 16'h4000, 26'h0800000, 26'h0800000);

        // Flush with two results in flight; the sample presented with flush is dropped
        do_flush(1'b1);
        tick(1'b1, 16'h4000, 26'h0100000, 26'h0100000);
        for (int i = 0; i < 4; i++) tick(1'b1, 16'h0000, 26'h0100000, 26'h0100000);
        tick(1'b1, 16'h0000, 26'h0300000, 26'h0300000);
        idle(2);

        // Asynchronous reset mid-stream
        tick(1'b1, 16'h4000, 26'h0100000, 26'h0100000);
        tick(1'b1, 16'h4000, 26'h0200000, 26'h0200000);
        tick(1'b1, 16'h4000, 26'h0300000, 26'h0300000);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data", {6'd0, out_data}, 32'd0);
        check("async_rst_data_nosat", {6'd0, out_data_ns}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; last_e = '0; last_n = '0;
        for (int i = 0; i < 3; i++) tick(1'b1, 16'h4000, 26'h0, 26'h0);
        idle(2);
        coef_commit = 1'b1;
        tick(1'b0, 16'h0000, '0, '0);
        for (int i = 0; i < 2; i++) tick(1'b1, 16'h4000, 26'h0, 26'h0);
        idle(2);
        wr(0, 14'h1000, 1'b1);
        tick(1'b1, 16'h4000, 26'h0200000, 26'h0200000);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fir_filter.md
Name: param_fir_filter

Overview:
- Parametrised direct-form FIR filter with TAPS taps, signed fixed-point data and runtime-loadable coefficients.
- Sits in the DSP datapath between the sample source and downstream processing.
- Generalises the fixed 6-tap constant-coefficient FIR: parametrised tap count and widths, valid-qualified sample flow, double-buffered coefficient bank, pipelined MAC, selectable output saturation.

Parameters:
TAPS, 6, number of filter taps (>=2)
INP_W, 16, input sample width, signed, INP_FRAC fractional bits
INP_FRAC, 14, input fractional bits
COEF_W, 14, coefficient width, signed two's complement, COEF_FRAC fractional bits
COEF_FRAC, 13, coefficient fractional bits
OUT_W, 26, output width, signed
OUT_FRAC, 22, output fractional bits (must be < INP_FRAC+COEF_FRAC)
SAT, 1, 1 = saturate output on overflow, 0 = two's-complement wrap

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous clear of delay line and pipeline
in_valid  input  1  in_data carries a sample this cycle
in_data  input  INP_W  input sample
coef_we  input  1  write coef_data into shadow bank
coef_addr  input  clog2(TAPS)  shadow tap index (0 = newest sample)
coef_data  input  COEF_W  coefficient value
coef_commit  input  1  copy shadow bank to active bank
out_valid  output  1  out_data valid, one-cycle pulse per sample
out_data  output  OUT_W  filtered sample

Behaviour:
- Reset (rst=1, async): delay line, shadow bank, active bank, all pipeline registers, out_valid and out_data cleared to 0.
- Delay line:
  - Shifts only on edges where in_valid=1; tap0 <= in_data, tap k <= tap k-1.
  - Holds when in_valid=0, so bubbles do not advance history.
- Pipeline, no backpressure:
  - Sample accepted at edge E0.
  - Edge E1: TAPS products tap_k*active_coef_k registered, valid bit v1 set.
  - Edge E2: rounded sum registered into out_data, out_valid=1.
  - Latency exactly 2 edges after acceptance; throughput one sample per cycle.
  - out_valid=0 in cycles with no result; out_data holds its last value.
- Arithmetic:
  - Product is INP_W+COEF_W bits with F=INP_FRAC+COEF_FRAC fractional bits.
  - Each product is rounded half-up to OUT_FRAC: arithmetic shift right by D=F-OUT_FRAC, plus bit D-1. Ties round toward +inf, so -0.5 LSB becomes 0.
  - Rounded terms are summed at full width OUT_W+clog2(TAPS) with no intermediate overflow.
  - SAT=1: result outside the OUT_W range clamps to max 0x1FFFFFF or min 0x2000000 (default widths).
  - SAT=0: low OUT_W bits kept.
- Coefficients:
  - coef_we writes shadow[coef_addr]; coef_addr>=TAPS is ignored.
  - coef_commit at edge E copies the whole shadow bank to the active bank at E.
  - Products registered at edges after E use the new bank; products registered at E use the old bank. No sample mixes banks.
  - coef_we and coef_commit in the same cycle: the written value is included in the commit (bypass).
  - Shadow writes without a commit never affect the output.
- flush (sync, higher priority than in_valid):
  - Clears delay line, v1 and out_valid at the next edge; in-flight results are discarded.
  - Coefficient banks are untouched. A sample presented with flush is dropped.
- rst asserted mid-stream: immediate clear, including coefficients. After release, the first in_valid produces out_valid 2 edges later using zero coefficients (output 0) until a commit.

Test Plan:
- Impulse:
  - Commit coefs c_k=0x1000 (0.5), feed in_data=0x4000 (1.0) then five zeros, all valid.
  - Expect six out_valid pulses of 0x0200000, latency 2, then 0.
- Rounding:
  - Commit c0=0x0010, others 0.
  - in_data=0x0001 gives out_data=1 (half LSB rounds up).
  - in_data=0xFFFF gives out_data=0.
- Saturation:
  - SAT=1, all c_k=0x1FFF, six samples 0x7FFF.
  - Expect 0x1FFFFFF on the sixth output; with 0x8000 inputs expect 0x2000000.
  - SAT=0: wrapped value matches the bit-exact model.
- Bubbles:
  - Impulse from the Impulse test with in_valid toggling 1,0,0,1.
  - Output sequence identical to the contiguous case; out_valid only 2 edges after each accepted sample.
- Coefficient swap:
  - Stream constant 0x4000, write a new bank over several cycles, then commit mid-stream.
  - No output changes before the commit; first output using the new bank is the one whose products register after the commit edge; the same-cycle write/commit value is applied.
- Flush and reset:
  - Assert flush with two results in flight: both dropped, next impulse starts from an empty history.
  - Assert rst asynchronously mid-stream: out_valid/out_data go to 0 immediately, and all-zero outputs follow until a commit.
